ex_stage_v: RTL and testbench

Execute stage that sits directly downstream of the ID/EX pipeline register. It consumes the registered ex_* bundle and computes the ALU result, resolves branches and jumps, and runs a multi-cycle shift-add multiplier. Results are registered into the EX/MEM pipeline register. It raises ex_busy to hold upstream stages and ex_flush/ex_target to redirect fetch.

---
 rtl/ex_stage_v.sv | 189 ++++++++++++++++++
 tb/tb_ex_stage_v.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_v.sv
`timescale 1ns/1ps
// Execute stage: ALU, branch/jump resolution and a 32-step shift-add multiplier feeding EX/MEM.
// ALU/branch/jump results register in one cycle; MUL takes 34 cycles; mem_stall freezes EX/MEM.
module ex_stage_v #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_isValid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_instr,
    input  logic [6:0]  ex_op,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_jump,
    input  logic        ex_branch,
    input  logic [3:0]  ex_alu_op,
    input  logic [31:0] ex_operand1,
    input  logic [31:0] ex_operand2,
    input  logic [31:0] ex_s_data,
    input  logic        mem_stall,
    output logic        ex_busy,
    output logic        ex_flush,
    output logic [31:0] ex_target,
    output logic        mem_isValid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_instr,
    output logic [6:0]  mem_op,
    output logic [4:0]  mem_rd,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic        mem_reg_write,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_s_data
);

    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [3:0] ALU_MUL = 4'd10;
    localparam int         CW      = $clog2(MUL_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

    mul_state_t    state;
    logic [CW-1:0] cnt;
    logic [31:0]   mcand;
    logic [31:0]   mplier;
    logic [31:0]   product;

    logic [4:0]  shamt;
    logic [31:0] alu_result;
    logic [31:0] result;
    logic [31:0] imm_i;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] jump_target;
    logic        taken;
    logic        is_mul;
    logic        busy_raw;
    logic        flush_raw;

    assign shamt  = ex_operand2[4:0];
    assign is_mul = ex_isValid & (ex_alu_op == ALU_MUL);

    always_comb begin
        alu_result = 32'd0;
        case (ex_alu_op)
            4'd0:    alu_result = ex_operand1 + ex_operand2;
            4'd1:    alu_result = ex_operand1 - ex_operand2;
            4'd2:    alu_result = ex_operand1 << shamt;
            4'd3:    alu_result = {31'd0, $signed(ex_operand1) < $signed(ex_operand2)};
            4'd4:    alu_result = {31'd0, ex_operand1 < ex_operand2};
            4'd5:    alu_result = ex_operand1 ^ ex_operand2;
            4'd6:    alu_result = ex_operand1 >> shamt;
            4'd7:    alu_result = $unsigned($signed(ex_operand1) >>> shamt);
            4'd8:    alu_result = ex_operand1 | ex_operand2;
            4'd9:    alu_result = ex_operand1 & ex_operand2;
            4'd10:   alu_result = product;
            default: alu_result = 32'd0;
        endcase
    end

    assign imm_i = {{20{ex_instr[31]}}, ex_instr[31:20]};
    assign imm_j = {{12{ex_instr[31]}}, ex_instr[19:12], ex_instr[20], ex_instr[30:21], 1'b0};
    assign imm_b = {{20{ex_instr[31]}}, ex_instr[7], ex_instr[30:25], ex_instr[11:8], 1'b0};

    always_comb begin
        taken = 1'b0;
        case (ex_instr[14:12])
            3'b000:  taken = (ex_operand1 == ex_operand2);
            3'b001:  taken = (ex_operand1 != ex_operand2);
            3'b100:  taken = ($signed(ex_operand1) < $signed(ex_operand2));
            3'b101:  taken = ($signed(ex_operand1) >= $signed(ex_operand2));
            3'b110:  taken = (ex_operand1 < ex_operand2);
            3'b111:  taken = (ex_operand1 >= ex_operand2);
            default: taken = 1'b0;
        endcase
    end

    assign jump_target = (ex_op == OP_JALR) ? ((ex_operand1 + imm_i) & ~32'd1)
                                            : (ex_pc + imm_j);

    always_comb begin
        result = alu_result;
        if (ex_jump)
            result = ex_pc + 32'd4;
        else if (ex_branch)
            result = 32'd0;
    end

    // Outputs forced quiet during reset: the combinational terms see live inputs.
    assign busy_raw  = mem_stall | (is_mul & (state != S_DONE));
    assign ex_busy   = ~reset & busy_raw;
    assign flush_raw = ex_isValid & (ex_jump | (ex_branch & taken)) & ~busy_raw;
    assign ex_flush  = ~reset & flush_raw;
    assign ex_target = ex_flush ? (ex_jump ? jump_target : ex_pc + imm_b) : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mcand   <= 32'd0;
            mplier  <= 32'd0;
            product <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mul & ~mem_stall) begin
                        mcand   <= ex_operand1;
                        mplier  <= ex_operand2;
                        product <= 32'd0;
                        cnt     <= '0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mplier[0])
                        product <= product + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(MUL_CYCLES - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    // Product is held here until EX/MEM is free to take it.
                    if (~mem_stall)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_isValid    <= 1'b0;
            mem_pc         <= 32'd0;
            mem_instr      <= 32'd0;
            mem_op         <= 7'd0;
            mem_rd         <= 5'd0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_alu_result <= 32'd0;
            mem_s_data     <= 32'd0;
        end else if (mem_stall) begin
            mem_isValid <= mem_isValid;
        end else if (busy_raw | ~ex_isValid) begin
            mem_isValid   <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
            mem_reg_write <= 1'b0;
        end else begin
            mem_isValid    <= 1'b1;
            mem_pc         <= ex_pc;
            mem_instr      <= ex_instr;
            mem_op         <= ex_op;
            mem_rd         <= ex_rd;
            mem_mem_read   <= ex_mem_read;
            mem_mem_write  <= ex_mem_write;
            mem_reg_write  <= ex_reg_write & (ex_rd != 5'd0);
            mem_alu_result <= result;
            mem_s_data     <= ex_s_data;
        end
    end

endmodule

// File: tb/tb_ex_stage_v.sv
`timescale 1ns/1ps
// Directed bench for ex_stage_v: ALU, branches, jumps, multiplier latency, stall and reset.
module tb_ex_stage_v;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_isValid;
    logic [31:0] ex_pc, ex_instr;
    logic [6:0]  ex_op;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_operand1, ex_operand2, ex_s_data;
    logic        mem_stall;
    logic        ex_busy, ex_flush;
    logic [31:0] ex_target;
    logic        mem_isValid;
    logic [31:0] mem_pc, mem_instr;
    logic [6:0]  mem_op;
    logic [4:0]  mem_rd;
    logic        mem_mem_read, mem_mem_write, mem_reg_write;
    logic [31:0] mem_alu_result, mem_s_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_stage_v #(.MUL_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .ex_isValid(ex_isValid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_jump(ex_jump), .ex_branch(ex_branch),
        .ex_alu_op(ex_alu_op), .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
        .ex_s_data(ex_s_data), .mem_stall(mem_stall), .ex_busy(ex_busy), .ex_flush(ex_flush),
        .ex_target(ex_target), .mem_isValid(mem_isValid), .mem_pc(mem_pc), .mem_instr(mem_instr),
        .mem_op(mem_op), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
        .mem_alu_result(mem_alu_result), .mem_s_data(mem_s_data)
    );

    task automatic set_idle();
        ex_isValid = 0; ex_pc = 0; ex_instr = 0; ex_op = 0; ex_rd = 0;
        ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_jump = 0; ex_branch = 0;
        ex_alu_op = 0; ex_operand1 = 0; ex_operand2 = 0; ex_s_data = 0; mem_stall = 0;
    endtask

    task automatic load_alu(input logic [3:0] aop, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        set_idle();
        ex_isValid = 1; ex_reg_write = 1; ex_op = 7'b0110011; ex_instr = 32'h0000_0033;
        ex_pc = 32'h40; ex_alu_op = aop; ex_operand1 = a; ex_operand2 = b; ex_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1;
        load_alu(4'd10, 32'd7, 32'd6, 5'd1);
        #1;
        vectors++; if (ex_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", ex_busy); end
        vectors++; if (ex_target !== 32'd0) begin miscompares++; $display("FAIL reset_target got %h want 0", ex_target); end
        tick();
        vectors++; if (mem_isValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", mem_isValid); end
        vectors++; if (mem_alu_result !== 32'd0) begin miscompares++; $display("FAIL reset_result got %h want 0", mem_alu_result); end
        reset = 0;
        set_idle();
        tick();
    endtask

    task automatic test_add();
        load_alu(4'd0, 32'd5, 32'd7, 5'd3);
        ex_s_data = 32'hCAFE_0001; ex_mem_write = 1; ex_pc = 32'h80;
        #1;
        vectors++; if (ex_busy !== 1'b0) begin miscompares++; $display("FAIL add_busy got %0b want 0", ex_busy); end
        tick();
        vectors++; if (mem_alu_result !== 32'd12) begin miscompares++; $display("FAIL add_result got %0d want 12", mem_alu_result); end
        vectors++; if (mem_reg_write !== 1'b1) begin miscompares++; $display("FAIL add_regwrite got %0b want 1", mem_reg_write); end
        vectors++; if (mem_rd !== 5'd3) begin miscompares++; $display("FAIL add_rd got %0d want 3", mem_rd); end
        vectors++; if (mem_isValid !== 1'b1) begin miscompares++; $display("FAIL add_valid got %0b want 1", mem_isValid); end
        vectors++; if (mem_s_data !== 32'hCAFE_0001 || mem_mem_write !== 1'b1 || mem_pc !== 32'h80)
            begin miscompares++; $display("FAIL add_fields got %h/%0b/%h want cafe0001/1/80", mem_s_data, mem_mem_write, mem_pc); end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  op_t [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11};
        logic [31:0] a_t  [10] = '{32'd5, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                   32'h80000000, 32'h80000000, 32'h0F00000F, 32'hFF00FF00, 32'd99};
        logic [31:0] b_t  [10] = '{32'd7, 32'h24, 32'd1, 32'd1, 32'hFF00FF00,
                                   32'h24, 32'h24, 32'h00F000F0, 32'h0FF00FF0, 32'd1};
        logic [31:0] e_t  [10] = '{32'hFFFFFFFE, 32'd16, 32'd1, 32'd0, 32'h0FF00FF0,
                                   32'h08000000, 32'hF8000000, 32'h0FF000FF, 32'h0F000F00, 32'd0};
        for (int i = 0; i < 10; i++) begin
            load_alu(op_t[i], a_t[i], b_t[i], 5'd7);
            tick();
            vectors++; if (mem_alu_result !== e_t[i])
                begin miscompares++; $display("FAIL alu_op%0d got %h want %h", op_t[i], mem_alu_result, e_t[i]); end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3_t [6] = '{3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
        logic [31:0] a_t  [6] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
        logic [31:0] b_t  [6] = '{32'd2, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5};
        logic        t_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        set_idle();
        ex_isValid = 1; ex_branch = 1; ex_op = 7'b1100011; ex_instr = 32'h0000_0863;
        ex_pc = 32'h100; ex_operand1 = 32'd9; ex_operand2 = 32'd9; ex_alu_op = 4'd1;
        #1;
        vectors++; if (ex_flush !== 1'b1) begin miscompares++; $display("FAIL beq_flush got %0b want 1", ex_flush); end
        vectors++; if (ex_target !== 32'h110) begin miscompares++; $display("FAIL beq_target got %h want 110", ex_target); end
        tick();
        vectors++; if (mem_alu_result !== 32'd0) begin miscompares++; $display("FAIL beq_result got %h want 0", mem_alu_result); end
        ex_operand2 = 32'd8;
        #1;
        vectors++; if (ex_flush !== 1'b0 || ex_target !== 32'd0)
            begin miscompares++; $display("FAIL beq_ne got %0b/%h want 0/0", ex_flush, ex_target); end
        for (int i = 0; i < 6; i++) begin
            ex_instr = 32'h0000_0863 | (32'(f3_t[i]) << 12);
            ex_operand1 = a_t[i]; ex_operand2 = b_t[i];
            #1;
            vectors++; if (ex_flush !== t_t[i] || ex_target !== (t_t[i] ? 32'h110 : 32'd0))
                begin miscompares++; $display("FAIL branch_f3_%0d got %0b/%h want %0b", f3_t[i], ex_flush, ex_target, t_t[i]); end
        end
        tick();
    endtask

    task automatic test_jump();
        set_idle();
        ex_isValid = 1; ex_jump = 1; ex_reg_write = 1; ex_rd = 5'd1;
        ex_op = 7'b1100111; ex_instr = 32'h0040_0067; ex_pc = 32'h300; ex_operand1 = 32'h203;
        #1;
        vectors++; if (ex_flush !== 1'b1 || ex_target !== 32'h206)
            begin miscompares++; $display("FAIL jalr got %0b/%h want 1/206", ex_flush, ex_target); end
        tick();
        vectors++; if (mem_alu_result !== 32'h304) begin miscompares++; $display("FAIL jalr_link got %h want 304", mem_alu_result); end
        ex_op = 7'b1101111; ex_instr = 32'h0080_006F;
        #1;
        vectors++; if (ex_flush !== 1'b1 || ex_target !== 32'h308)
            begin miscompares++; $display("FAIL jal got %0b/%h want 1/308", ex_flush, ex_target); end
        tick();
    endtask

    task automatic test_rd_zero();
        load_alu(4'd0, 32'd1, 32'd1, 5'd0);
        tick();
        vectors++; if (mem_reg_write !== 1'b0 || mem_isValid !== 1'b1)
            begin miscompares++; $display("FAIL rd0 got rw=%0b v=%0b want 0/1", mem_reg_write, mem_isValid); end
        set_idle();
        tick();
        vectors++; if (mem_isValid !== 1'b0 || mem_alu_result !== 32'd2)
            begin miscompares++; $display("FAIL bubble_hold got v=%0b r=%h want 0/2", mem_isValid, mem_alu_result); end
    endtask

    task automatic test_stall();
        load_alu(4'd0, 32'd5, 32'd7, 5'd3);
        tick();
        load_alu(4'd0, 32'd10, 32'd20, 5'd4);
        ex_jump = 1; ex_op = 7'b1101111; ex_instr = 32'h0080_006F; ex_jump = 0;
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (ex_busy !== 1'b1 || ex_flush !== 1'b0)
                begin miscompares++; $display("FAIL stall_ctl%0d got b=%0b f=%0b want 1/0", i, ex_busy, ex_flush); end
            tick();
            vectors++; if (mem_alu_result !== 32'd12 || mem_rd !== 5'd3 || mem_isValid !== 1'b1)
                begin miscompares++; $display("FAIL stall_hold%0d got %0d rd%0d want 12 rd3", i, mem_alu_result, mem_rd); end
        end
        mem_stall = 0;
        #1;
        vectors++; if (ex_busy !== 1'b0) begin miscompares++; $display("FAIL stall_release got %0b want 0", ex_busy); end
        tick();
        vectors++; if (mem_alu_result !== 32'd30 || mem_rd !== 5'd4)
            begin miscompares++; $display("FAIL stall_update got %0d rd%0d want 30 rd4", mem_alu_result, mem_rd); end
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cycles = 0;
        load_alu(4'd10, a, b, 5'd5);
        #1;
        while (ex_busy === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
            if (ex_busy === 1'b1) begin
                vectors++; if (mem_isValid !== 1'b0)
                    begin miscompares++; $display("FAIL mul_bubble cycle %0d got %0b want 0", cycles, mem_isValid); end
            end
        end
        vectors++; if (cycles != 33) begin miscompares++; $display("FAIL mul_busy_cycles got %0d want 33", cycles); end
        @(posedge clk); #1;
        vectors++; if (mem_alu_result !== exp || mem_isValid !== 1'b1)
            begin miscompares++; $display("FAIL mul_result got %h v=%0b want %h", mem_alu_result, mem_isValid, exp); end
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid_mul();
        load_alu(4'd10, 32'd5, 32'd5, 5'd2);
        for (int i = 0; i < 11; i++) tick();
        vectors++; if (ex_busy !== 1'b1) begin miscompares++; $display("FAIL midmul_busy got %0b want 1", ex_busy); end
        reset = 1;
        #1;
        vectors++; if (ex_busy !== 1'b0) begin miscompares++; $display("FAIL midmul_reset_busy got %0b want 0", ex_busy); end
        tick();
        vectors++; if (mem_isValid !== 0 || mem_alu_result !== 0 || mem_pc !== 0 || mem_rd !== 0 ||
                       mem_instr !== 0 || mem_s_data !== 0 || mem_op !== 0 || mem_reg_write !== 0)
            begin miscompares++; $display("FAIL midmul_clear got v=%0b r=%h pc=%h want all 0", mem_isValid, mem_alu_result, mem_pc); end
        reset = 0;
        test_mul(32'd3, 32'd3, 32'd9);
    endtask

    initial begin
        set_idle();
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_jump();
        test_rd_zero();
        test_stall();
        test_mul(32'd7, 32'd6, 32'd42);
        test_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
